// File: rtl/uart_boot_loader_pkg.sv
// Shared definitions for the UART boot loader: FSM states, sync default, word width.
package uart_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } boot_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         WORD_W            = 32;

endpackage

// File: rtl/uart_boot_loader_word_assembler.sv
// Little-endian byte-to-word shifter; word_ready pulses the cycle after the 4th byte.
module boot_word_assembler
    import uart_boot_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic              strobe_en,
    input  logic [7:0]        byte_data,
    output logic [WORD_W-1:0] word,
    output logic [1:0]        byte_cnt,
    output logic              word_ready
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word       <= '0;
            byte_cnt   <= '0;
            word_ready <= 1'b0;
        end else begin
            word_ready <= byte_valid && strobe_en && (byte_cnt == 2'd3);
            if (byte_valid) begin
                word     <= {byte_data, word[WORD_W-1:8]};
                byte_cnt <= byte_cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Frame parser loading an instruction image from UART bytes while holding the CPU in reset.
// Optional trailing checksum byte: define UART_BOOT_LOADER_CHECKSUM_EN.
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter int         ADDR_W    = 10,
    parameter int         BASE_ADDR = 0,
    parameter int         MAX_WORDS = 1024,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int WC_W = $clog2(MAX_WORDS + 1);

    boot_state_t       state, state_next;
    logic [WC_W-1:0]   word_cnt;
    logic [WORD_W-1:0] asm_word;
    logic [1:0]        asm_cnt;
    logic              asm_ready;
    logic              asm_valid;
    logic              restart;
    logic              last_write;
    logic [31:0]       len_value;
    logic              len_bad;

    assign restart    = rx_valid && (rx_data == SYNC_BYTE) &&
                        (state == ST_SYNC || state == ST_DONE || state == ST_ERR);
    assign last_write = (state == ST_DATA) && mem_we && (word_cnt == WC_W'(1));
    // The LEN bytes reuse the assembler; the 4th byte completes the count combinationally.
    assign len_value  = {rx_data, asm_word[31:8]};
    assign len_bad    = (len_value == 32'd0) || (len_value > 32'(MAX_WORDS));
    // A byte landing in the final write cycle belongs to the trailer, not to the image.
    assign asm_valid  = rx_valid && !rx_err &&
                        (state == ST_LEN || (state == ST_DATA && !last_write));

    boot_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (restart),
        .byte_valid (asm_valid),
        .strobe_en  (state == ST_DATA),
        .byte_data  (rx_data),
        .word       (asm_word),
        .byte_cnt   (asm_cnt),
        .word_ready (asm_ready)
    );

    assign mem_we    = asm_ready;
    assign mem_wdata = asm_word;

`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    logic [7:0] csum_q;
    logic       csum_ok;

    assign csum_ok = (rx_data == csum_q);

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            csum_q <= '0;
        end else if (asm_valid) begin
            csum_q <= csum_q + rx_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_SYNC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_SYNC, ST_DONE, ST_ERR: begin
                if (restart) state_next = ST_LEN;
            end
            ST_LEN: begin
                if (rx_valid) begin
                    if (rx_err)                         state_next = ST_ERR;
                    else if (asm_cnt == 2'd3)           state_next = len_bad ? ST_ERR : ST_DATA;
                end
            end
            ST_DATA: begin
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
                if (last_write) begin
                    if (rx_valid) state_next = (rx_err || !csum_ok) ? ST_ERR : ST_DONE;
                    else          state_next = ST_CSUM;
                end else if (rx_valid && rx_err) begin
                    state_next = ST_ERR;
                end
`else
                if (last_write)                 state_next = ST_DONE;
                else if (rx_valid && rx_err)    state_next = ST_ERR;
`endif
            end
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (rx_valid) state_next = (rx_err || !csum_ok) ? ST_ERR : ST_DONE;
            end
`endif
            default: state_next = ST_SYNC;
        endcase
    end

    always_comb begin
        busy    = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);
        done    = (state == ST_DONE);
        err     = (state == ST_ERR);
        cpu_rst = (state != ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            mem_addr <= ADDR_W'(BASE_ADDR);
            word_cnt <= '0;
        end else begin
            if (mem_we) begin
                mem_addr <= mem_addr + ADDR_W'(1);
            end
            if (state == ST_LEN && asm_valid && asm_cnt == 2'd3 && !len_bad) begin
                word_cnt <= len_value[WC_W-1:0];
            end else if (mem_we && state == ST_DATA) begin
                word_cnt <= word_cnt - WC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader (ADDR_W=2, BASE_ADDR=3, MAX_WORDS=4); follows the checksum macro.
module tb_uart_boot_loader;

    localparam int         AW    = 2;
    localparam int         BASE  = 3;
    localparam int         MAXW  = 4;
    localparam logic [7:0] SYNC  = 8'hA5;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_err = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_rst;
    logic          busy;
    logic          done;
    logic          err;

    wr_t           sb[$];
    logic [31:0]   wbuf [0:3];
    int            checks = 0;
    int            failures = 0;
    int            writes = 0;
    int            rst_glitch = 0;
    int            snap;

    uart_boot_loader #(
        .ADDR_W    (AW),
        .BASE_ADDR (BASE),
        .MAX_WORDS (MAXW),
        .SYNC_BYTE (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_err    (rx_err),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            wr_t e;
            writes++;
            if (sb.size() == 0) begin
                check("unexpected_we", 32'(mem_we), 32'd0);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(mem_addr), e.addr);
                check("wr_data", mem_wdata, e.data);
            end
        end
        if (!rst && !done && !cpu_rst) rst_glitch++;
    end

    task automatic send_byte(input logic [7:0] b, input logic e);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        rx_err   = e;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_err   = 1'b0;
        end
    endtask

    // err_at: index of the data byte flagged with rx_err, or -1 for none.
    task automatic send_frame(input logic [31:0] len, input int unsigned nwords,
                              input logic [7:0] csum_adj, input int err_at);
        logic [7:0]    sum;
        logic [7:0]    b;
        logic [AW-1:0] a;
        int            idx;
        bit            stop;
        sum  = '0;
        a    = AW'(BASE);
        idx  = 0;
        stop = 1'b0;
        send_byte(SYNC, 1'b0);
        for (int unsigned i = 0; i < 4; i++) begin
            b = len[8*i +: 8];
            sum = sum + b;
            send_byte(b, 1'b0);
        end
        for (int unsigned w = 0; w < nwords; w++) begin
            if (!stop) begin
                if (err_at < 0 || err_at >= int'((w + 1) * 4))
                    sb.push_back('{addr: 32'(a), data: wbuf[w]});
                a = a + AW'(1);
                for (int unsigned i = 0; i < 4; i++) begin
                    if (!stop) begin
                        b = wbuf[w][8*i +: 8];
                        sum = sum + b;
                        send_byte(b, idx == err_at);
                        if (idx == err_at) stop = 1'b1;
                        idx++;
                    end
                end
            end
        end
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
        if (!stop && nwords > 0) send_byte(sum + csum_adj, 1'b0);
`endif
        idle(1);
    endtask

    task automatic wait_end(input string tag, input logic [1:0] exp_done_err);
        int unsigned n = 0;
        while (!(done || err) && n < 64) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'({done, err}), 32'(exp_done_err));
    endtask

    initial begin
        wbuf[0] = 32'h44332211;
        wbuf[1] = 32'h88776655;
        wbuf[2] = 32'hDEADBEEF;
        wbuf[3] = 32'h0BADF00D;

        idle(3);
        rst = 1'b0;
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'(BASE));
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // noise in SYNC, then a good 2-word frame (addresses 3 then 0)
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        idle(2);
        check("noise_busy", 32'(busy), 32'd0);
        send_frame(32'd2, 2, 8'h00, -1);
        wait_end("good_end", 2'b10);
        idle(1);
        check("good_cpu_rst", 32'(cpu_rst), 32'd0);
        check("good_busy", 32'(busy), 32'd0);
        check("good_sb_empty", 32'(sb.size()), 32'd0);
        check("good_writes", 32'(writes), 32'd2);

`ifdef UART_BOOT_LOADER_CHECKSUM_EN
        send_frame(32'd2, 2, 8'h01, -1);
        wait_end("bad_csum_end", 2'b01);
        check("bad_csum_cpu_rst", 32'(cpu_rst), 32'd1);
        check("bad_csum_sb_empty", 32'(sb.size()), 32'd0);
        send_frame(32'd2, 2, 8'h00, -1);
        wait_end("recover_end", 2'b10);
        check("recover_cpu_rst", 32'(cpu_rst), 32'd0);
`endif

        // SYNC in DONE restarts; zero length then fails without writes
        snap = writes;
        send_byte(SYNC, 1'b0);
        idle(1);
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_cpu_rst", 32'(cpu_rst), 32'd1);
        check("restart_addr", 32'(mem_addr), 32'(BASE));
        check("restart_done", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b0);
        idle(1);
        wait_end("len0_end", 2'b01);
        check("len0_writes", 32'(writes), 32'(snap));

        send_frame(32'(MAXW + 1), 0, 8'h00, -1);
        wait_end("len_max_end", 2'b01);
        check("len_max_writes", 32'(writes), 32'(snap));

        // rx_err on the 3rd data byte
        send_frame(32'd2, 2, 8'h00, 2);
        wait_end("rxerr_end", 2'b01);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        idle(8);
        check("rxerr_still_err", 32'(err), 32'd1);
        check("rxerr_writes", 32'(writes), 32'(snap));

        // reset mid-DATA, then a complete frame
        sb.push_back('{addr: 32'(BASE), data: wbuf[0]});
        send_byte(SYNC, 1'b0);
        send_byte(8'h02, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b0);
        for (int unsigned i = 0; i < 4; i++) send_byte(wbuf[0][8*i +: 8], 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        idle(1);
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        idle(1);
        check("mid_rst_addr", 32'(mem_addr), 32'(BASE));
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
        rst = 1'b0;
        idle(1);
        send_frame(32'd2, 2, 8'h00, -1);
        wait_end("after_rst_end", 2'b10);
        check("after_rst_sb_empty", 32'(sb.size()), 32'd0);
        check("cpu_rst_glitch", 32'(rst_glitch), 32'd0);

        idle(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
